palette_lut: RTL
================

# palette_lut

Runtime-writable, parametrised colour palette for the VGA pixel path. Maps a per-pixel palette index to an RGB triple through a two-stage registered pipeline. Supports host writes to any entry at any time. Includes a global brightness fade engine for screen fade-in and fade-out. It sits between the sprite/background index generators and the VGA output registers, and replaces fixed per-image palette ROMs.

## Interface
Parameters:
- INDEX_W, 5, palette index width; DEPTH = 2**INDEX_W entries
- COLOR_W, 4, bits per colour channel
- FADE_DIV, 262144, cycles per brightness step (≥1)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- rd_valid  in  1  pixel lookup request this cycle
- rd_index  in  INDEX_W  palette index to look up
- red, green, blue  out  COLOR_W each  scaled colour, registered
- out_valid  out  1  red/green/blue correspond to a request issued 2 cycles earlier
- wr_en  in  1  write palette entry
- wr_index  in  INDEX_W  entry to write
- wr_color  in  3*COLOR_W  {red, green, blue} to store
- fade_start  in  1  one-cycle pulse that loads a new brightness target
- fade_target  in  COLOR_W+1  target brightness, 0..2**COLOR_W
- fade_busy  out  1  brightness differs from target and is stepping
- brightness  out  COLOR_W+1  current global brightness

## Operation
- Storage: DEPTH × 3*COLOR_W register array.
  - On Reset, entry i is set to grey: every channel = i mod 2**COLOR_W.
  - The write takes effect at the clock edge when wr_en=1.
- Lookup pipeline:
  - Stage 1: when rd_valid=1, capture the table entry at rd_index into s1_color, and set s1_valid=rd_valid.
  - Stage 2: each channel out = (s1_channel × brightness) >> COLOR_W. The product is COLOR_W+(COLOR_W+1) bits wide. The result is truncated (floor) and registered into red/green/blue. out_valid = s1_valid.
  - When s1_valid=0, red/green/blue hold their previous value.
  - brightness = 2**COLOR_W is an exact identity (15×16>>4 = 15).
- Same-cycle read and write to the same index: the stage-1 capture takes the old value (read-first). The new value is visible to requests issued from the next cycle onward.
- Fade FSM with states IDLE and STEP. It holds target (COLOR_W+1 bits) and a divider counter of clog2(FADE_DIV) bits.
  - fade_start loads target = min(fade_target, 2**COLOR_W). It is accepted in either state.
  - In IDLE on fade_start:
    - If the clamped target ≠ brightness, go to STEP with counter=0.
    - Otherwise stay in IDLE.
  - In STEP:
    - The counter increments every cycle.
    - When counter = FADE_DIV−1, the counter returns to 0 and brightness moves 1 toward target.
    - If the new brightness equals target, go to IDLE.
  - fade_start in STEP retargets without resetting the counter. If the new target equals the current brightness, go to IDLE on the next edge.
  - fade_busy = (state == STEP).
- Brightness changes apply to stage 2 of whatever pixel is in flight. There is no frame alignment; the caller issues fades during blanking if tearing matters.

## Timing
- Reset (asynchronous, any cycle, including mid-fade or mid-pipeline) sets:
  - red=green=blue=0, out_valid=0, s1_valid=0
  - brightness=2**COLOR_W, target=2**COLOR_W
  - FSM=IDLE, counter=0, fade_busy=0
  - table = grey ramp
- Lookup latency: exactly 2 cycles, fully pipelined, one request per cycle, no stalls and no backpressure.
- Write latency: 1 cycle to visibility.
- Fade duration: |target − brightness| × FADE_DIV cycles from the fade_start edge to fade_busy falling. The first step lands FADE_DIV cycles after entering STEP.
- brightness and fade_busy are registered.

## Test plan
- Reset with COLOR_W=4, INDEX_W=5. Issue rd_valid with rd_index=0..31 back-to-back → out_valid high for 32 cycles starting 2 cycles later, RGB = {i mod 16}×3 in order. brightness=16, fade_busy=0.
- Write index 7 = {F,0,8}, then read index 7 → {F,0,8}. On the same cycle write index 3 = {1,2,3} and read index 3 → old value {3,3,3}. A read on the following cycle → {1,2,3}.
- With FADE_DIV=4, fade_start with target 8 from 16 → fade_busy high for 32 cycles. brightness decrements every 4 cycles. A steady read of {F,F,F} ends at {7,7,7}.
- fade_target=31 → target is clamped to 16. Issued at brightness 16, fade_busy stays 0.
- Mid-fade (brightness 12, heading to 8), fade_start with target 14 → direction reverses without a counter reset, and fade_busy falls at 14. A fade_start with target equal to the current brightness → IDLE on the next cycle.
- Assert Reset during STEP with reads in flight → outputs 0, out_valid 0, and brightness 16 immediately without a clock. A palette entry written before Reset reads back its grey default.

Source files
------------

// File: rtl/palette_lut.sv
// Runtime-writable colour palette with a two-stage lookup pipeline and a
// global brightness fade engine that scales every looked-up pixel.
module palette_lut #(
    parameter int INDEX_W  = 5,
    parameter int COLOR_W  = 4,
    parameter int FADE_DIV = 262144
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   rd_valid,
    input  logic [INDEX_W-1:0]     rd_index,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   out_valid,
    input  logic                   wr_en,
    input  logic [INDEX_W-1:0]     wr_index,
    input  logic [3*COLOR_W-1:0]   wr_color,
    input  logic                   fade_start,
    input  logic [COLOR_W:0]       fade_target,
    output logic                   fade_busy,
    output logic [COLOR_W:0]       brightness
);

    localparam int DEPTH = 2 ** INDEX_W;
    localparam int CW    = 3 * COLOR_W;
    localparam int BW    = COLOR_W + 1;
    localparam int CNT_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [BW-1:0]    FULL     = BW'(2 ** COLOR_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_DIV - 1);

    typedef enum logic {IDLE, STEP} fade_state_t;

    logic [CW-1:0]      pal [DEPTH];
    logic [CW-1:0]      s1_color;
    logic               s1_valid;
    fade_state_t        state;
    logic [BW-1:0]      target;
    logic [CNT_W-1:0]   cnt;
    logic [BW-1:0]      clamped;
    logic [BW-1:0]      eff_target;
    logic [BW-1:0]      next_bright;
    logic               step_now;

    function automatic logic [COLOR_W-1:0] grey(input int i);
        return COLOR_W'(i % (2 ** COLOR_W));
    endfunction

    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [BW-1:0] b);
        logic [COLOR_W+BW-1:0] p;
        p = {{BW{1'b0}}, c} * {{COLOR_W{1'b0}}, b};
        return COLOR_W'(p >> COLOR_W);
    endfunction

    // Palette storage; reset restores the grey ramp.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal[i] <= {3{grey(i)}};
            end
        end else if (wr_en) begin
            pal[wr_index] <= wr_color;
        end
    end

    // Stage 1 samples the old entry on a same-cycle write (read-first).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_color <= '0;
        end else begin
            s1_valid <= rd_valid;
            if (rd_valid) begin
                s1_color <= pal[rd_index];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                red   <= scale(s1_color[CW-1 -: COLOR_W], brightness);
                green <= scale(s1_color[2*COLOR_W-1 -: COLOR_W], brightness);
                blue  <= scale(s1_color[COLOR_W-1:0], brightness);
            end
        end
    end

    always_comb begin
        clamped     = (fade_target > FULL) ? FULL : fade_target;
        eff_target  = fade_start ? clamped : target;
        step_now    = (cnt == CNT_LAST);
        next_bright = (brightness < eff_target) ? brightness + BW'(1)
                                                : brightness - BW'(1);
    end

    // A retarget during STEP keeps the divider phase running.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            target     <= FULL;
            brightness <= FULL;
        end else begin
            if (fade_start) begin
                target <= clamped;
            end
            case (state)
                IDLE: begin
                    if (fade_start && clamped != brightness) begin
                        state <= STEP;
                        cnt   <= '0;
                    end
                end
                STEP: begin
                    if (eff_target == brightness) begin
                        state <= IDLE;
                    end else if (step_now) begin
                        cnt        <= '0;
                        brightness <= next_bright;
                        if (next_bright == eff_target) begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fade_busy = (state == STEP);

endmodule
